alu_seq_ctrl: RTL and testbench

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

---
 rtl/alu_seq_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: step-button sequencer that captures two operands and an
// opcode from a switch bank, drives them to an external combinational ALU,
// waits ALU_LAT cycles and latches the result for display.
// Optional result chaining (DONE + press with sw[15]=1 feeds the result back
// into operand A) is compiled in only when ALU_SEQ_CHAIN_EN is defined.
module alu_seq_ctrl #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ALU_LAT         = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn,
  input  logic [15:0]      sw,
  input  logic [WIDTH-1:0] alu_y,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  output logic [WIDTH-1:0] disp_y,
  output logic [3:0]       disp_op,
  output logic [1:0]       state_code,
  output logic             busy,
  output logic             done
);

  localparam int DCW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int LCW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef enum logic [2:0] {
    S_GET_A,
    S_GET_B,
    S_GET_OP,
    S_EXEC,
    S_DONE
  } state_t;

  // ---------------- button conditioning ----------------
  logic [1:0]     sync_q, sync_d;
  logic           stable_q, stable_d;
  logic [DCW-1:0] db_cnt_q, db_cnt_d;
  logic           press_q, press_d;
  logic           btn_s;

  assign btn_s = sync_q[1];

  // Synchronize, then accept a new level only after DEBOUNCE_CYCLES
  // consecutive disagreeing samples; a rising acceptance emits one press.
  always_comb begin
    sync_d   = {sync_q[0], btn};
    stable_d = stable_q;
    db_cnt_d = '0;
    press_d  = 1'b0;
    if (btn_s != stable_q) begin
      if (db_cnt_q == DCW'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = btn_s;
        press_d  = btn_s;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // Debouncer state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      db_cnt_q <= '0;
      press_q  <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      db_cnt_q <= db_cnt_d;
      press_q  <= press_d;
    end
  end

  // ---------------- sequencer ----------------
  state_t           state_q, state_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, disp_y_q, disp_y_d;
  logic [3:0]       alu_op_q, alu_op_d, disp_op_q, disp_op_d;
  logic [LCW-1:0]   lat_cnt_q, lat_cnt_d;
  logic [1:0]       state_code_q, state_code_d;
  logic             busy_q, busy_d, done_q, done_d;

  // Next-state and capture logic; switches are only sampled on a press.
  always_comb begin
    state_d   = state_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_op_d  = alu_op_q;
    disp_y_d  = disp_y_q;
    disp_op_d = disp_op_q;
    lat_cnt_d = lat_cnt_q;
    case (state_q)
      S_GET_A: if (press_q) begin
        alu_a_d = sw[WIDTH-1:0];
        state_d = S_GET_B;
      end
      S_GET_B: if (press_q) begin
        alu_b_d = sw[WIDTH-1:0];
        state_d = S_GET_OP;
      end
      S_GET_OP: if (press_q) begin
        alu_op_d  = sw[3:0];
        disp_op_d = sw[3:0];
        lat_cnt_d = '0;
        state_d   = S_EXEC;
      end
      // Presses here fall on the floor: nothing in this branch looks at press_q.
      S_EXEC: begin
        if (lat_cnt_q == LCW'(ALU_LAT - 1)) begin
          disp_y_d = alu_y;
          state_d  = S_DONE;
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end
      S_DONE: if (press_q) begin
`ifdef ALU_SEQ_CHAIN_EN
        if (sw[15]) begin
          alu_a_d = disp_y_q;
          state_d = S_GET_B;
        end else begin
          state_d = S_GET_A;
        end
`else
        state_d = S_GET_A;
`endif
      end
      default: state_d = S_GET_A;
    endcase

    // Status outputs are registered from the next state so they line up
    // with state_q rather than lagging it by a cycle.
    case (state_d)
      S_GET_A:  state_code_d = 2'd0;
      S_GET_B:  state_code_d = 2'd1;
      S_GET_OP: state_code_d = 2'd2;
      default:  state_code_d = 2'd3;
    endcase
    busy_d = (state_d == S_EXEC);
    done_d = (state_d == S_DONE);
  end

  // Sequencer registers; reset wins over any pending press or EXEC update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_GET_A;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      disp_y_q     <= '0;
      disp_op_q    <= '0;
      lat_cnt_q    <= '0;
      state_code_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      disp_y_q     <= disp_y_d;
      disp_op_q    <= disp_op_d;
      lat_cnt_q    <= lat_cnt_d;
      state_code_q <= state_code_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Upper switch bits are only meaningful in some configurations.
  logic unused_sw;
  assign unused_sw = ^sw;

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign disp_y     = disp_y_q;
  assign disp_op    = disp_op_q;
  assign state_code = state_code_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl. The ALU is modelled as alu_y = alu_a + alu_b.
// A second instance with a long ALU_LAT lets a debounced press land inside EXEC.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        btn = 1'b0, btn2 = 1'b0;
  logic [15:0] sw = '0;

  logic [7:0] alu_y, alu_a, alu_b, disp_y;
  logic [3:0] alu_op, disp_op;
  logic [1:0] state_code;
  logic       busy, done;

  logic [7:0] alu_y2, alu_a2, alu_b2, disp_y2;
  logic [3:0] alu_op2, disp_op2;
  logic [1:0] state_code2;
  logic       busy2, done2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign alu_y  = alu_a + alu_b;
  assign alu_y2 = alu_a2 + alu_b2;

  alu_seq_ctrl #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .ALU_LAT(2)) u_dut (
    .clk(clk), .reset(reset), .btn(btn), .sw(sw), .alu_y(alu_y),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .disp_y(disp_y),
    .disp_op(disp_op), .state_code(state_code), .busy(busy), .done(done)
  );

  alu_seq_ctrl #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .ALU_LAT(16)) u_lat (
    .clk(clk), .reset(reset), .btn(btn2), .sw(sw), .alu_y(alu_y2),
    .alu_a(alu_a2), .alu_b(alu_b2), .alu_op(alu_op2), .disp_y(disp_y2),
    .disp_op(disp_op2), .state_code(state_code2), .busy(busy2), .done(done2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Full press: long enough to debounce high, then long enough to settle low.
  task automatic press(input bit sel);
    if (sel) btn2 = 1'b1; else btn = 1'b1;
    repeat (8) @(negedge clk);
    if (sel) btn2 = 1'b0; else btn = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".a"},     32'(alu_a), 32'h0);
    check({tag, ".b"},     32'(alu_b), 32'h0);
    check({tag, ".op"},    32'(alu_op), 32'h0);
    check({tag, ".y"},     32'(disp_y), 32'h0);
    check({tag, ".dop"},   32'(disp_op), 32'h0);
    check({tag, ".state"}, 32'(state_code), 32'h0);
    check({tag, ".busy"},  32'(busy), 32'h0);
    check({tag, ".done"},  32'(done), 32'h0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_all_zero("reset");

    // Glitchy button never debounces
    btn = 1'b1; @(negedge clk);
    btn = 1'b0; @(negedge clk);
    btn = 1'b1; @(negedge clk);
    btn = 1'b0;
    repeat (12) @(negedge clk);
    check("glitch.state", 32'(state_code), 32'd0);
    check("glitch.a",     32'(alu_a), 32'h0);

    // Capture timing: press pulse after 6 edges, operand visible the next cycle
    sw = 16'h0055;
    btn = 1'b1;
    repeat (6) @(negedge clk);
    check("cap.a_before",     32'(alu_a), 32'h0);
    check("cap.state_before", 32'(state_code), 32'd0);
    @(negedge clk);
    check("cap.a_after",     32'(alu_a), 32'h55);
    check("cap.state_after", 32'(state_code), 32'd1);
    btn = 1'b0;
    repeat (8) @(negedge clk);

    // Switch changes without a press do nothing
    sw = 16'h00AA;
    repeat (3) @(negedge clk);
    check("sw_idle.a", 32'(alu_a), 32'h55);
    check("sw_idle.b", 32'(alu_b), 32'h0);

    // Two-cycle reset mid-activity
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_all_zero("midreset");

    // Reset in the same cycle as a press pulse wins
    sw = 16'h0077;
    btn = 1'b1;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_prio.state", 32'(state_code), 32'd0);
    check("rst_prio.a",     32'(alu_a), 32'h0);
    reset = 1'b0;
    btn = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_prio.state_later", 32'(state_code), 32'd0);

    // Held button gives exactly one press
    sw = 16'h0012;
    btn = 1'b1;
    repeat (30) @(negedge clk);
    check("held.state", 32'(state_code), 32'd1);
    check("held.a",     32'(alu_a), 32'h12);
    btn = 1'b0;
    repeat (8) @(negedge clk);

    sw = 16'h0034;
    press(1'b0);
    check("getb.b",     32'(alu_b), 32'h34);
    check("getb.state", 32'(state_code), 32'd2);

    // Opcode press and EXEC latency
    sw = 16'h0003;
    btn = 1'b1;
    repeat (6) @(negedge clk);
    check("exec.pre_state", 32'(state_code), 32'd2);
    check("exec.pre_busy",  32'(busy), 32'd0);
    @(negedge clk);
    check("exec.c0_state", 32'(state_code), 32'd3);
    check("exec.c0_busy",  32'(busy), 32'd1);
    check("exec.c0_done",  32'(done), 32'd0);
    check("exec.op",       32'(alu_op), 32'd3);
    check("exec.c0_y",     32'(disp_y), 32'h0);
    @(negedge clk);
    check("exec.c1_busy", 32'(busy), 32'd1);
    check("exec.c1_y",    32'(disp_y), 32'h0);
    @(negedge clk);
    check("done.busy", 32'(busy), 32'd0);
    check("done.done", 32'(done), 32'd1);
    check("done.y",    32'(disp_y), 32'h46);
    check("done.dop",  32'(disp_op), 32'd3);
    btn = 1'b0;
    repeat (8) @(negedge clk);
    sw = 16'h7F0F;
    repeat (3) @(negedge clk);
    check("done_hold.y",     32'(disp_y), 32'h46);
    check("done_hold.state", 32'(state_code), 32'd3);

    // Press in DONE with sw[15]=1
    sw = 16'h8000;
    press(1'b0);
`ifdef ALU_SEQ_CHAIN_EN
    check("chain.state", 32'(state_code), 32'd1);
    check("chain.a",     32'(alu_a), 32'h46);
`else
    check("chain.state", 32'(state_code), 32'd0);
    check("chain.a",     32'(alu_a), 32'h12);
`endif
    check("chain.b",    32'(alu_b), 32'h34);
    check("chain.op",   32'(alu_op), 32'd3);
    check("chain.y",    32'(disp_y), 32'h46);
    check("chain.done", 32'(done), 32'd0);

    // Reset one cycle into EXEC aborts the result update
`ifndef ALU_SEQ_CHAIN_EN
    sw = 16'h0012;
    press(1'b0);
`endif
    sw = 16'h0034;
    press(1'b0);
    sw = 16'h0003;
    btn = 1'b1;
    repeat (7) @(negedge clk);
    check("abort.busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    btn = 1'b0;
    @(negedge clk);
    check("abort.state", 32'(state_code), 32'd0);
    check("abort.busy",  32'(busy), 32'd0);
    check("abort.y",     32'(disp_y), 32'h0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("abort.y_later",     32'(disp_y), 32'h0);
    check("abort.state_later", 32'(state_code), 32'd0);

    // Long-latency instance: a press debounced inside EXEC is discarded
    sw = 16'h0010;
    press(1'b1);
    sw = 16'h0020;
    press(1'b1);
    sw = 16'h0005;
    btn2 = 1'b1;
    repeat (7) @(negedge clk);
    check("lat.enter_busy", 32'(busy2), 32'd1);
    btn2 = 1'b0;
    repeat (6) @(negedge clk);
    btn2 = 1'b1;
    repeat (9) @(negedge clk);
    check("lat.c15_busy",  32'(busy2), 32'd1);
    check("lat.c15_state", 32'(state_code2), 32'd3);
    @(negedge clk);
    check("lat.done",  32'(done2), 32'd1);
    check("lat.y",     32'(disp_y2), 32'h30);
    check("lat.dop",   32'(disp_op2), 32'd5);
    repeat (10) @(negedge clk);
    check("lat.stay_done",  32'(done2), 32'd1);
    check("lat.stay_state", 32'(state_code2), 32'd3);
    btn2 = 1'b0;
    repeat (10) @(negedge clk);
    check("lat.release_state", 32'(state_code2), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
